// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection sequencer with a pedestrian phase. A prescaler
// divides CLOCK_50 down to a 1 s tick that drives a per-phase countdown.
module intersection_phase_scheduler #(
    parameter int TICK_DIV  = 50000000,
    parameter int T_GREEN_A = 15,
    parameter int T_GREEN_B = 10,
    parameter int T_YELLOW  = 5,
    parameter int T_ALLRED  = 1,
    parameter int T_WALK    = 8
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       car_b,
    input  logic       hold,
    output logic [2:0] lamps_a,
    output logic [2:0] lamps_b,
    output logic       walk,
    output logic       ped_ack,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic [2:0] phase,
    output logic       tick
);

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        ALLRED_1 = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        ALLRED_2 = 3'd5,
        PED_WALK = 3'd6
    } state_t;

    localparam logic [25:0] PRESC_MAX = 26'(TICK_DIV - 1);
    localparam logic [6:0]  D_GA = 7'(T_GREEN_A);
    localparam logic [6:0]  D_GB = 7'(T_GREEN_B);
    localparam logic [6:0]  D_Y  = 7'(T_YELLOW);
    localparam logic [6:0]  D_AR = 7'(T_ALLRED);
    localparam logic [6:0]  D_W  = 7'(T_WALK);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    state_t      r_state;
    logic [6:0]  r_count;
    logic [25:0] r_presc;
    logic        r_tick;
    logic        r_ped_pending;
    logic        r_ped_ack;
    logic [2:0]  r_lamps_a;
    logic [2:0]  r_lamps_b;
    logic        r_walk;

    state_t      w_next_state;
    logic [6:0]  w_next_count;
    logic        w_demand;
    logic        w_enter_walk;
    logic [6:0]  w_lamp_bits;

    // Duration loaded on entry to each state.
    function automatic logic [6:0] dur_of(input state_t s);
        case (s)
            A_GREEN:  dur_of = D_GA;
            A_YELLOW: dur_of = D_Y;
            ALLRED_1: dur_of = D_AR;
            B_GREEN:  dur_of = D_GB;
            B_YELLOW: dur_of = D_Y;
            ALLRED_2: dur_of = D_AR;
            PED_WALK: dur_of = D_W;
            default:  dur_of = D_GA;
        endcase
    endfunction

    // Successor when the countdown of a state expires; pedestrians beat car_b.
    function automatic state_t succ_of(input state_t s, input logic ped);
        case (s)
            A_GREEN:  succ_of = A_YELLOW;
            A_YELLOW: succ_of = ALLRED_1;
            ALLRED_1: succ_of = ped ? PED_WALK : B_GREEN;
            B_GREEN:  succ_of = B_YELLOW;
            B_YELLOW: succ_of = ALLRED_2;
            PED_WALK: succ_of = ALLRED_2;
            default:  succ_of = A_GREEN;
        endcase
    endfunction

    // Packed as {lamps_a, lamps_b, walk}.
    function automatic logic [6:0] lamps_of(input state_t s);
        case (s)
            A_GREEN:  lamps_of = {LAMP_G, LAMP_R, 1'b0};
            A_YELLOW: lamps_of = {LAMP_Y, LAMP_R, 1'b0};
            B_GREEN:  lamps_of = {LAMP_R, LAMP_G, 1'b0};
            B_YELLOW: lamps_of = {LAMP_R, LAMP_Y, 1'b0};
            PED_WALK: lamps_of = {LAMP_R, LAMP_R, 1'b1};
            default:  lamps_of = {LAMP_R, LAMP_R, 1'b0};
        endcase
    endfunction

    assign w_demand = car_b | r_ped_pending;

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            A_GREEN: begin
                if (r_tick) begin
                    if (r_count > 7'd1) begin
                        w_next_count = r_count - 7'd1;
                    end else if (w_demand) begin
                        w_next_state = A_YELLOW;
                        w_next_count = D_Y;
                    end else begin
                        w_next_count = 7'd0;
                    end
                end
            end
            A_YELLOW, ALLRED_1, B_GREEN, B_YELLOW, ALLRED_2, PED_WALK: begin
                if (r_tick) begin
                    if (r_count > 7'd1) begin
                        w_next_count = r_count - 7'd1;
                    end else begin
                        w_next_state = succ_of(r_state, r_ped_pending);
                        w_next_count = dur_of(succ_of(r_state, r_ped_pending));
                    end
                end
            end
            default: begin
                w_next_state = A_GREEN;
                w_next_count = D_GA;
            end
        endcase
    end

    assign w_enter_walk = (w_next_state == PED_WALK) && (r_state != PED_WALK);
    assign w_lamp_bits  = lamps_of(w_next_state);

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_presc <= 26'd0;
            r_tick  <= 1'b0;
        end else if (hold) begin
            r_tick  <= 1'b0;
        end else begin
            r_tick  <= (r_presc == PRESC_MAX);
            r_presc <= (r_presc == PRESC_MAX) ? 26'd0 : r_presc + 26'd1;
        end
    end

    // Lamps are registered from the next-state decode so they move with phase.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_state       <= A_GREEN;
            r_count       <= D_GA;
            r_ped_pending <= 1'b0;
            r_ped_ack     <= 1'b0;
            r_lamps_a     <= LAMP_G;
            r_lamps_b     <= LAMP_R;
            r_walk        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_count       <= w_next_count;
            r_ped_pending <= w_enter_walk ? 1'b0 : (r_ped_pending | ped_req);
            r_ped_ack     <= w_enter_walk;
            r_lamps_a     <= w_lamp_bits[6:4];
            r_lamps_b     <= w_lamp_bits[3:1];
            r_walk        <= w_lamp_bits[0];
        end
    end

    assign lamps_a  = r_lamps_a;
    assign lamps_b  = r_lamps_b;
    assign walk     = r_walk;
    assign ped_ack  = r_ped_ack;
    assign phase    = r_state;
    assign tick     = r_tick;
    assign cnt_tens = 4'(r_count / 7'd10);
    assign cnt_ones = 4'(r_count % 7'd10);

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Sequences a two-road intersection (main road A, side road B) plus a pedestrian crossing phase.
- Generates its own 1 s tick from CLOCK_50 and arbitrates between side-road car demand and pedestrian demand.
- Drives per-road R/Y/G lamps, a walk lamp and a two-digit BCD countdown. The countdown feeds the board's seven-segment decoders and LED drivers.

Parameters:
TICK_DIV, 50000000, CLOCK_50 cycles per 1 s tick (legal range 2..2^26)
T_GREEN_A, 15, main-road minimum green, seconds (1..99)
T_GREEN_B, 10, side-road green, seconds (1..99)
T_YELLOW, 5, yellow duration for either road, seconds (1..99)
T_ALLRED, 1, all-red clearance, seconds (1..99)
T_WALK, 8, pedestrian walk duration, seconds (1..99)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
ped_req  in  1  pedestrian button, already synchronised, level
car_b  in  1  side-road vehicle sensor, already synchronised, level
hold  in  1  freeze: prescaler and countdown stop, outputs unchanged
lamps_a  out  3  {R,Y,G} for road A, one-hot
lamps_b  out  3  {R,Y,G} for road B, one-hot
walk  out  1  pedestrian walk lamp
ped_ack  out  1  one-cycle pulse when the walk phase is granted
cnt_tens  out  4  BCD tens of remaining seconds
cnt_ones  out  4  BCD ones of remaining seconds
phase  out  3  current state encoding (see below)
tick  out  1  one-cycle 1 s strobe, for display blink logic

Behaviour:
- Reset is asynchronous and active-high. Reset is applied at any time, including mid-phase, and restores the reset state below.
  - Reset state: phase=A_GREEN, count=T_GREEN_A, prescaler=0, ped_pending=0, ped_ack=0, tick=0.
  - Lamp outputs follow the phase decode, so lamps_a=001, lamps_b=100 and walk=0 in reset.
- Prescaler:
  - Counts 0..TICK_DIV-1 while hold=0; tick=1 for exactly the cycle the prescaler wraps to 0.
  - While hold=1 the prescaler holds its value and tick=0.
- States and their encoding on phase:
  - 0 A_GREEN
  - 1 A_YELLOW
  - 2 ALLRED_1
  - 3 B_GREEN
  - 4 B_YELLOW
  - 5 ALLRED_2
  - 6 PED_WALK
  - Encoding 7 is unused and recovers to A_GREEN on the next clock.
- Lamp decode:
  - A_GREEN: A=G, B=R.
  - A_YELLOW: A=Y, B=R.
  - ALLRED_x: both R.
  - B_GREEN: A=R, B=G.
  - B_YELLOW: A=R, B=Y.
  - PED_WALK: both R, walk=1.
  - walk=0 in every other state.
- Countdown:
  - On entry to a state, count loads that state's duration.
  - On each tick with count>1, count decrements by 1.
  - On a tick with count==1, the state advances and the next state's duration is loaded in the same cycle, so the display shows D..1 for exactly D ticks.
- A_GREEN extension:
  - On a tick with count<=1, the state advances to A_YELLOW if demand=(car_b|ped_pending)=1.
  - Otherwise count becomes 0 and the state stays in A_GREEN. The display holds 00 until a tick sees demand, which then advances.
- Transitions:
  - A_YELLOW->ALLRED_1.
  - ALLRED_1->PED_WALK if ped_pending=1, else ALLRED_1->B_GREEN. Pedestrian demand has priority over car_b.
  - B_GREEN->B_YELLOW->ALLRED_2.
  - PED_WALK->ALLRED_2.
  - ALLRED_2->A_GREEN.
- ped_pending:
  - Set on any clock with ped_req=1.
  - Cleared on the clock that enters PED_WALK; clear wins over a simultaneous set.
  - A ped_req still held after the grant re-latches on the following clock and is served in the next cycle round.
- ped_ack: registered, 1 for the single cycle following entry into PED_WALK.
- Registered outputs: count, phase and lamps all change on the same clock edge.
- BCD: cnt_tens = count/10 and cnt_ones = count%10, combinational from the 7-bit count. Values never exceed 99.
- Simultaneous events:
  - A tick and a hold rising edge on the same cycle: the tick is already generated and is honoured. Only later ticks are suppressed.
  - ped_req during PED_WALK: latched for the next cycle round.

Test Plan:
- Use TICK_DIV=4 for all scenarios.
- Reset release, car_b=0, ped_req=0 -> A_GREEN; count runs 15..1, then sits at 00 with lamps_a=001 indefinitely.
- Hold in A_GREEN at count 00, assert car_b -> next tick A_YELLOW (05); then ALLRED_1 (01), B_GREEN (10), B_YELLOW (05), ALLRED_2 (01), A_GREEN (15). Each step is 4-cycle ticks, lamps one-hot throughout.
- Pulse ped_req for 1 cycle during A_GREEN count 12 with car_b=1 -> after ALLRED_1 enter PED_WALK with walk=1 and a single ped_ack pulse; B_GREEN skipped; ALLRED_2 follows, then A_GREEN.
- Hold ped_req high across PED_WALK entry -> ped_pending re-set the next clock; second full cycle round also grants PED_WALK.
- Assert hold for 20 cycles in B_GREEN at count 07 -> tick stays 0, count stays 07; releasing resumes with the prescaler continuing from its frozen value.
- Assert rst asynchronously mid B_YELLOW count 03 (between clock edges) -> outputs go immediately to phase 0, count 15, lamps_a=001, lamps_b=100, walk=0, ped_ack=0.
